// File: rtl/rgb_led_arbiter.sv
// rgb_led_arbiter: fixed-priority sharing of one RGB LED with minimum display time and PWM brightness
module rgb_led_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int PWM_WIDTH  = 8,
   parameter int TICK_DIV   = 12000,
   parameter int HOLD_TICKS = 250
) (
   input  logic                             clock_12mhz,
   input  logic                             reset,
   input  logic [NUM_REQ-1:0]               req,
   input  logic [NUM_REQ*3*PWM_WIDTH-1:0]   req_rgb,
   output logic [NUM_REQ-1:0]               grant,
   output logic                             busy,
   output logic                             led_red,
   output logic                             led_green,
   output logic                             led_blue
);
   localparam int CW = 3*PWM_WIDTH;
   localparam int TW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
   localparam int HW = $clog2(HOLD_TICKS+1);
   localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
   localparam logic IDLE = 1'b0;
   localparam logic SHOW = 1'b1;
   logic                 state;
   logic [TW-1:0]        tick_cnt;
   logic                 tick;
   logic [HW-1:0]        hold;
   logic [PWM_WIDTH-1:0] pwm_cnt;
   logic [CW-1:0]        lat_rgb;
   logic [CW-1:0]        act_rgb;
   logic [CW-1:0]        win_rgb;
   logic [IW-1:0]        win;
   assign tick    = tick_cnt == TW'(TICK_DIV-1);
   assign busy    = state == SHOW;
   assign win_rgb = req_rgb[int'(win)*CW +: CW];
   // lowest set request index wins
   always_comb begin
      win = '0;
      for (int i = NUM_REQ-1; i >= 0; i--) win = req[i] ? IW'(i) : win;
   end
   // free-running display tick divider
   always_ff @(posedge clock_12mhz or posedge reset) begin
      if (reset) tick_cnt <= '0;
      else tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
   end
   // PWM: duties only change at the period boundary so no partial periods appear
   always_ff @(posedge clock_12mhz or posedge reset) begin
      if (reset) begin
         pwm_cnt   <= '0;
         act_rgb   <= '0;
         led_red   <= 1'b0;
         led_green <= 1'b0;
         led_blue  <= 1'b0;
      end else begin
         pwm_cnt   <= pwm_cnt + PWM_WIDTH'(1);
         act_rgb   <= &pwm_cnt ? lat_rgb : act_rgb;
         led_red   <= pwm_cnt < act_rgb[CW-1 -: PWM_WIDTH];
         led_green <= pwm_cnt < act_rgb[2*PWM_WIDTH-1 -: PWM_WIDTH];
         led_blue  <= pwm_cnt < act_rgb[PWM_WIDTH-1:0];
      end
   end
   // arbitration: grant in IDLE or at hold expiry, otherwise count down the hold
   always_ff @(posedge clock_12mhz or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         grant   <= '0;
         hold    <= '0;
         lat_rgb <= '0;
      end else if (state == IDLE || (tick && hold == HW'(1))) begin
         state   <= |req ? SHOW : IDLE;
         grant   <= |req ? NUM_REQ'(1) << win : '0;
         hold    <= |req ? HW'(HOLD_TICKS) : hold;
         lat_rgb <= |req ? win_rgb : '0;
      end else if (tick) begin
         hold <= hold - HW'(1);
      end
   end
endmodule
